// File: rtl/ci_pkg.sv
// Shared custom-instruction definitions: FSM states, bus widths, default error result.
package ci_pkg;

   localparam int unsigned CI_DATA_W = 32;
   localparam int unsigned CI_ID_W   = 8;

   typedef logic [CI_DATA_W-1:0] ci_data_t;
   typedef logic [CI_ID_W-1:0]   ci_id_t;

   localparam ci_data_t CI_ERROR_RESULT = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      ERR
   } ci_state_e;

endpackage

// File: rtl/ci_if.sv
// Custom-instruction bus between the CPU-side initiator and the responders.
interface ci_if;
   import ci_pkg::*;

   logic     ciStart;
   ci_data_t ciValueA;
   ci_data_t ciValueB;
   ci_id_t   ciN;
   logic     ciDone;
   ci_data_t ciResult;

   modport master (
      output ciStart, ciValueA, ciValueB, ciN,
      input  ciDone, ciResult
   );

   modport slave (
      input  ciStart, ciValueA, ciValueB, ciN,
      output ciDone, ciResult
   );

endinterface

// File: rtl/ci_latency_counter.sv
// Saturating start-to-done cycle counter with watchdog compare.
module ci_latency_counter #(
   parameter int unsigned LAT_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear_i,
   input  logic                 enable_i,
   output logic [LAT_WIDTH-1:0] count_o,
   output logic                 timeout_o
);

   localparam logic [LAT_WIDTH-1:0] LAST_COUNT = LAT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [LAT_WIDTH-1:0] count_q, count_d;

   // Clear has priority; increment stops at all-ones.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != '1)) begin
         count_d = count_q + LAT_WIDTH'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o   = count_q;
   assign timeout_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/ci_initiator.sv
// CPU-side custom-instruction initiator: issues a CI, stalls the pipeline until
// done or watchdog timeout, returns the result and the measured latency.
module ci_initiator
   import ci_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned LAT_WIDTH      = 16,
   parameter ci_data_t    ERROR_RESULT   = CI_ERROR_RESULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 issue,
   input  ci_data_t             opA,
   input  ci_data_t             opB,
   input  ci_id_t               ciId,
   ci_if.master                 ci,
   output logic                 cpuStall,
   output logic                 resultValid,
   output ci_data_t             result,
   output logic                 timeoutError,
   output logic [LAT_WIDTH-1:0] lastLatency
);

   ci_state_e            state_q, state_d;
   ci_data_t             valA_q, valA_d;
   ci_data_t             valB_q, valB_d;
   ci_id_t               ciN_q, ciN_d;
   ci_data_t             result_q, result_d;
   logic                 timeoutErr_q, timeoutErr_d;
   logic [LAT_WIDTH-1:0] lastLat_q, lastLat_d;
   logic                 start_q, stall_q, valid_q;

   logic                 cnt_clear, cnt_en, cnt_timeout;
   logic [LAT_WIDTH-1:0] count;

   ci_latency_counter #(
      .LAT_WIDTH      (LAT_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_lat (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (cnt_clear),
      .enable_i  (cnt_en),
      .count_o   (count),
      .timeout_o (cnt_timeout)
   );

   // Next-state decode plus operand/result capture; done beats timeout in WAIT.
   always_comb begin
      state_d      = state_q;
      valA_d       = valA_q;
      valB_d       = valB_q;
      ciN_d        = ciN_q;
      result_d     = result_q;
      timeoutErr_d = timeoutErr_q;
      lastLat_d    = lastLat_q;
      cnt_clear    = 1'b0;
      cnt_en       = 1'b0;
      case (state_q)
         IDLE: begin
            if (issue) begin
               valA_d  = opA;
               valB_d  = opB;
               ciN_d   = ciId;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_clear = 1'b1;
            if (ci.ciDone) begin
               result_d     = ci.ciResult;
               timeoutErr_d = 1'b0;
               lastLat_d    = '0;
               state_d      = DONE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_en = 1'b1;
            if (ci.ciDone) begin
               result_d     = ci.ciResult;
               timeoutErr_d = 1'b0;
               lastLat_d    = (count == '1) ? count : count + LAT_WIDTH'(1);
               state_d      = DONE;
            end else if (cnt_timeout) begin
               result_d     = ERROR_RESULT;
               timeoutErr_d = 1'b1;
               state_d      = ERR;
            end
         end
         DONE, ERR: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // State, data and registered control outputs decoded from the next state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         valA_q       <= '0;
         valB_q       <= '0;
         ciN_q        <= '0;
         result_q     <= '0;
         timeoutErr_q <= 1'b0;
         lastLat_q    <= '0;
         start_q      <= 1'b0;
         stall_q      <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         valA_q       <= valA_d;
         valB_q       <= valB_d;
         ciN_q        <= ciN_d;
         result_q     <= result_d;
         timeoutErr_q <= timeoutErr_d;
         lastLat_q    <= lastLat_d;
         start_q      <= (state_d == ISSUE);
         stall_q      <= (state_d == ISSUE) || (state_d == WAIT);
         valid_q      <= (state_d == DONE) || (state_d == ERR);
      end
   end

   assign ci.ciStart   = start_q;
   assign ci.ciValueA  = valA_q;
   assign ci.ciValueB  = valB_q;
   assign ci.ciN       = ciN_q;
   assign cpuStall     = stall_q;
   assign resultValid  = valid_q;
   assign result       = result_q;
   assign timeoutError = timeoutErr_q;
   assign lastLatency  = lastLat_q;

endmodule

// File: tb/tb_ci_initiator.sv
// Directed bench for ci_initiator with a short watchdog (TIMEOUT_CYCLES=8).
module tb_ci_initiator;
   import ci_pkg::*;

   localparam int unsigned LAT_W = 16;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             issue = 1'b0;
   ci_data_t         opA   = '0;
   ci_data_t         opB   = '0;
   ci_id_t           ciId  = '0;
   logic             cpuStall, resultValid, timeoutError;
   ci_data_t         result;
   logic [LAT_W-1:0] lastLatency;

   int n_cmp = 0;
   int n_bad = 0;

   ci_if ci();

   ci_initiator #(
      .TIMEOUT_CYCLES (8),
      .LAT_WIDTH      (LAT_W),
      .ERROR_RESULT   (32'hDEAD_BEEF)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .issue        (issue),
      .opA          (opA),
      .opB          (opB),
      .ciId         (ciId),
      .ci           (ci),
      .cpuStall     (cpuStall),
      .resultValid  (resultValid),
      .result       (result),
      .timeoutError (timeoutError),
      .lastLatency  (lastLatency)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; issue = 1'b1; opA = 32'hFFFF_FFFF; opB = 32'hFFFF_FFFF; ciId = 8'hFF;
      tick(); tick();
      n_cmp++;
      if ({ci.ciStart, cpuStall, resultValid, timeoutError} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_ctrl: got %b expected 0000", {ci.ciStart, cpuStall, resultValid, timeoutError});
      end
      n_cmp++;
      if ({ci.ciValueA, ci.ciValueB, ci.ciN, result} !== 104'h0) begin
         n_bad++; $display("FAIL reset_data: got %h expected 0", {ci.ciValueA, ci.ciValueB, ci.ciN, result});
      end
      n_cmp++;
      if (lastLatency !== 16'd0) begin
         n_bad++; $display("FAIL reset_lat: got %0d expected 0", lastLatency);
      end
      issue = 1'b0; opA = '0; opB = '0; ciId = '0;
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({ci.ciStart, cpuStall, resultValid} !== 3'b000) begin
         n_bad++; $display("FAIL reset_release: got %b expected 000", {ci.ciStart, cpuStall, resultValid});
      end
   endtask

   task automatic test_basic();
      int stalls = 0;
      int starts = 0;
      issue = 1'b1; opA = 32'h0000_0001; opB = 32'h0000_0101; ciId = 8'h00;
      tick(); // ISSUE
      n_cmp++;
      if ({ci.ciValueA, ci.ciValueB, ci.ciN} !== {32'h1, 32'h101, 8'h00}) begin
         n_bad++; $display("FAIL basic_operands: got %h expected %h", {ci.ciValueA, ci.ciValueB, ci.ciN}, {32'h1, 32'h101, 8'h00});
      end
      for (int c = 0; c < 4; c++) begin
         if (cpuStall) stalls++;
         if (ci.ciStart) starts++;
         if (c == 3) begin ci.ciDone = 1'b1; ci.ciResult = 32'h0000_0042; end
         tick();
      end
      ci.ciDone = 1'b0; ci.ciResult = '0; issue = 1'b0;
      n_cmp++;
      if ({resultValid, timeoutError, cpuStall} !== 3'b100) begin
         n_bad++; $display("FAIL basic_done_ctrl: got %b expected 100", {resultValid, timeoutError, cpuStall});
      end
      n_cmp++;
      if (result !== 32'h0000_0042) begin
         n_bad++; $display("FAIL basic_result: got %h expected 00000042", result);
      end
      n_cmp++;
      if (lastLatency !== 16'd3) begin
         n_bad++; $display("FAIL basic_latency: got %0d expected 3", lastLatency);
      end
      n_cmp++;
      if (stalls !== 4 || starts !== 1) begin
         n_bad++; $display("FAIL basic_stall_start: got stall=%0d start=%0d expected stall=4 start=1", stalls, starts);
      end
      tick();
      n_cmp++;
      if ({resultValid, result} !== {1'b0, 32'h0000_0042}) begin
         n_bad++; $display("FAIL basic_hold: got %h expected 000000042", {resultValid, result});
      end
   endtask

   task automatic test_timeout();
      issue = 1'b1; opA = 32'hAAAA_0001; opB = 32'h5555_0002; ciId = 8'h07;
      tick(); // ISSUE
      tick(); // WAIT count 0
      for (int w = 0; w < 8; w++) begin
         n_cmp++;
         if ({cpuStall, resultValid} !== 2'b10) begin
            n_bad++; $display("FAIL timeout_wait%0d: got %b expected 10", w, {cpuStall, resultValid});
         end
         tick();
      end
      issue = 1'b0; // ERR cycle
      n_cmp++;
      if ({resultValid, timeoutError, cpuStall} !== 3'b110) begin
         n_bad++; $display("FAIL timeout_err_ctrl: got %b expected 110", {resultValid, timeoutError, cpuStall});
      end
      n_cmp++;
      if (result !== 32'hDEAD_BEEF) begin
         n_bad++; $display("FAIL timeout_result: got %h expected deadbeef", result);
      end
      n_cmp++;
      if (lastLatency !== 16'd3) begin
         n_bad++; $display("FAIL timeout_latency_kept: got %0d expected 3", lastLatency);
      end
      tick(); tick();
      ci.ciDone = 1'b1; ci.ciResult = 32'h5555_AAAA;
      tick();
      ci.ciDone = 1'b0; ci.ciResult = '0;
      n_cmp++;
      if ({resultValid, cpuStall, ci.ciStart, timeoutError, result} !== {4'b0001, 32'hDEAD_BEEF}) begin
         n_bad++; $display("FAIL timeout_stray_done: got %h expected %h", {resultValid, cpuStall, ci.ciStart, timeoutError, result}, {4'b0001, 32'hDEAD_BEEF});
      end
      tick();
      n_cmp++;
      if (resultValid !== 1'b0) begin
         n_bad++; $display("FAIL timeout_stray_valid: got %b expected 0", resultValid);
      end
   endtask

   task automatic test_coincident();
      issue = 1'b1; opA = 32'h0000_0010; opB = 32'h0000_0020; ciId = 8'h09;
      tick(); // ISSUE
      tick(); // WAIT count 0
      for (int w = 0; w < 7; w++) tick(); // WAIT count 7
      n_cmp++;
      if ({cpuStall, resultValid} !== 2'b10) begin
         n_bad++; $display("FAIL coinc_still_waiting: got %b expected 10", {cpuStall, resultValid});
      end
      ci.ciDone = 1'b1; ci.ciResult = 32'hCAFE_F00D;
      tick();
      ci.ciDone = 1'b0; ci.ciResult = '0; issue = 1'b0;
      n_cmp++;
      if ({resultValid, timeoutError} !== 2'b10) begin
         n_bad++; $display("FAIL coinc_ctrl: got %b expected 10", {resultValid, timeoutError});
      end
      n_cmp++;
      if (result !== 32'hCAFE_F00D) begin
         n_bad++; $display("FAIL coinc_result: got %h expected cafef00d", result);
      end
      n_cmp++;
      if (lastLatency !== 16'd8) begin
         n_bad++; $display("FAIL coinc_latency: got %0d expected 8", lastLatency);
      end
      tick();
   endtask

   task automatic test_zero_latency();
      issue = 1'b1; opA = 32'h0000_0003; opB = 32'h0000_0004; ciId = 8'h05;
      tick(); // ISSUE
      n_cmp++;
      if ({ci.ciStart, cpuStall} !== 2'b11) begin
         n_bad++; $display("FAIL zero_issue: got %b expected 11", {ci.ciStart, cpuStall});
      end
      ci.ciDone = 1'b1; ci.ciResult = 32'h1234_5678;
      tick();
      ci.ciDone = 1'b0; ci.ciResult = '0; issue = 1'b0;
      n_cmp++;
      if ({resultValid, timeoutError, cpuStall, ci.ciStart} !== 4'b1000) begin
         n_bad++; $display("FAIL zero_done_ctrl: got %b expected 1000", {resultValid, timeoutError, cpuStall, ci.ciStart});
      end
      n_cmp++;
      if ({result, lastLatency} !== {32'h1234_5678, 16'd0}) begin
         n_bad++; $display("FAIL zero_result_lat: got %h expected 123456780000", {result, lastLatency});
      end
      tick();
      n_cmp++;
      if (resultValid !== 1'b0) begin
         n_bad++; $display("FAIL zero_pulse: got %b expected 0", resultValid);
      end
   endtask

   task automatic test_back_to_back();
      issue = 1'b1; ciId = 8'h01; opA = 32'h0000_0011; opB = 32'h0000_0012;
      tick(); // ISSUE #1
      n_cmp++;
      if ({ci.ciStart, ci.ciN, ci.ciValueA, ci.ciValueB} !== {1'b1, 8'h01, 32'h11, 32'h12}) begin
         n_bad++; $display("FAIL b2b_start1: got %h expected %h", {ci.ciStart, ci.ciN, ci.ciValueA, ci.ciValueB}, {1'b1, 8'h01, 32'h11, 32'h12});
      end
      opA = 32'hBAD0_0001;
      tick(); // WAIT
      n_cmp++;
      if ({ci.ciN, ci.ciValueA, ci.ciValueB} !== {8'h01, 32'h11, 32'h12}) begin
         n_bad++; $display("FAIL b2b_hold1: got %h expected %h", {ci.ciN, ci.ciValueA, ci.ciValueB}, {8'h01, 32'h11, 32'h12});
      end
      ci.ciDone = 1'b1; ci.ciResult = 32'h0000_0100;
      tick(); // DONE #1
      ci.ciDone = 1'b0; ci.ciResult = '0;
      n_cmp++;
      if ({resultValid, result, ci.ciN, ci.ciValueA, lastLatency} !== {1'b1, 32'h100, 8'h01, 32'h11, 16'd1}) begin
         n_bad++; $display("FAIL b2b_done1: got %h expected %h", {resultValid, result, ci.ciN, ci.ciValueA, lastLatency}, {1'b1, 32'h100, 8'h01, 32'h11, 16'd1});
      end
      ciId = 8'h02; opA = 32'h0000_0021; opB = 32'h0000_0022;
      tick(); // IDLE, issue still high
      n_cmp++;
      if ({ci.ciStart, resultValid, ci.ciN, ci.ciValueA} !== {2'b00, 8'h01, 32'h11}) begin
         n_bad++; $display("FAIL b2b_idle: got %h expected %h", {ci.ciStart, resultValid, ci.ciN, ci.ciValueA}, {2'b00, 8'h01, 32'h11});
      end
      tick(); // ISSUE #2, two cycles after first resultValid
      n_cmp++;
      if ({ci.ciStart, ci.ciN, ci.ciValueA, ci.ciValueB} !== {1'b1, 8'h02, 32'h21, 32'h22}) begin
         n_bad++; $display("FAIL b2b_start2: got %h expected %h", {ci.ciStart, ci.ciN, ci.ciValueA, ci.ciValueB}, {1'b1, 8'h02, 32'h21, 32'h22});
      end
      opB = 32'hBAD0_0002;
      tick(); // WAIT count 0
      n_cmp++;
      if ({ci.ciStart, ci.ciN, ci.ciValueA, ci.ciValueB} !== {1'b0, 8'h02, 32'h21, 32'h22}) begin
         n_bad++; $display("FAIL b2b_hold2: got %h expected %h", {ci.ciStart, ci.ciN, ci.ciValueA, ci.ciValueB}, {1'b0, 8'h02, 32'h21, 32'h22});
      end
      tick(); // WAIT count 1
      ci.ciDone = 1'b1; ci.ciResult = 32'h0000_0200;
      tick(); // DONE #2
      ci.ciDone = 1'b0; ci.ciResult = '0; issue = 1'b0;
      n_cmp++;
      if ({resultValid, result, lastLatency} !== {1'b1, 32'h200, 16'd2}) begin
         n_bad++; $display("FAIL b2b_done2: got %h expected %h", {resultValid, result, lastLatency}, {1'b1, 32'h200, 16'd2});
      end
      tick(); tick();
      n_cmp++;
      if ({ci.ciStart, cpuStall} !== 2'b00) begin
         n_bad++; $display("FAIL b2b_no_third: got %b expected 00", {ci.ciStart, cpuStall});
      end
   endtask

   task automatic test_reset_mid();
      issue = 1'b1; opA = 32'h0000_0007; opB = 32'h0000_0008; ciId = 8'h0C;
      tick(); tick(); tick(); // WAIT count 1
      n_cmp++;
      if (cpuStall !== 1'b1) begin
         n_bad++; $display("FAIL rstmid_pre: got %b expected 1", cpuStall);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({ci.ciStart, cpuStall, resultValid, timeoutError, lastLatency} !== 20'h0) begin
         n_bad++; $display("FAIL rstmid_ctrl: got %h expected 0", {ci.ciStart, cpuStall, resultValid, timeoutError, lastLatency});
      end
      n_cmp++;
      if ({ci.ciValueA, ci.ciValueB, ci.ciN, result} !== 104'h0) begin
         n_bad++; $display("FAIL rstmid_data: got %h expected 0", {ci.ciValueA, ci.ciValueB, ci.ciN, result});
      end
      issue = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      ci.ciDone = 1'b1; ci.ciResult = 32'h0BAD_0BAD;
      tick();
      ci.ciDone = 1'b0; ci.ciResult = '0;
      n_cmp++;
      if ({resultValid, cpuStall, result} !== 34'h0) begin
         n_bad++; $display("FAIL rstmid_stray: got %h expected 0", {resultValid, cpuStall, result});
      end
      tick();
      n_cmp++;
      if (resultValid !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_stray_valid: got %b expected 0", resultValid);
      end
      issue = 1'b1; opA = 32'h0000_0005; opB = 32'h0000_0006; ciId = 8'h03;
      tick(); // ISSUE
      n_cmp++;
      if ({ci.ciStart, ci.ciN, ci.ciValueA} !== {1'b1, 8'h03, 32'h5}) begin
         n_bad++; $display("FAIL rstmid_restart: got %h expected %h", {ci.ciStart, ci.ciN, ci.ciValueA}, {1'b1, 8'h03, 32'h5});
      end
      tick(); tick(); // WAIT count 1
      ci.ciDone = 1'b1; ci.ciResult = 32'h0000_0077;
      tick();
      ci.ciDone = 1'b0; ci.ciResult = '0; issue = 1'b0;
      n_cmp++;
      if ({resultValid, timeoutError, result, lastLatency} !== {2'b10, 32'h77, 16'd2}) begin
         n_bad++; $display("FAIL rstmid_complete: got %h expected %h", {resultValid, timeoutError, result, lastLatency}, {2'b10, 32'h77, 16'd2});
      end
      tick();
   endtask

   initial begin
      ci.ciDone   = 1'b0;
      ci.ciResult = '0;
      test_reset();
      test_basic();
      test_timeout();
      test_coincident();
      test_zero_latency();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before 100000ns");
      $fatal(1);
   end

endmodule
